// File: rtl/addsub_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the
// single adder_sub_32bit datapath.
package addsub_arb_pkg;

  localparam int DATA_W = 32;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Operation captured from the winning requester.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              mode;
  } s1_data_t;

  // Adder result waiting for the consumer.
  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              carry;
  } s2_data_t;

endpackage

// File: rtl/addsub_rr_arbiter_if.sv
// Request/response bundle between the client blocks (master) and the
// arbiter (slave).
interface addsub_rr_arbiter_if #(
  parameter int NREQ = 4
) ();
  import addsub_arb_pkg::*;

  localparam int IDW = $clog2(NREQ);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. A requester holds valid and its operand slice stable until it is
  // accepted (or withdraws by dropping valid); ready may depend on valid. The
  // response side holds rsp_* stable while rsp_valid=1 and rsp_ready=0.
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ-1:0]        req_cin;
  logic [NREQ-1:0]        req_mode;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [DATA_W-1:0]      rsp_sum;
  logic                   rsp_carry;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

endinterface

// File: rtl/adder_sub_32bit.sv
// 32-bit adder/subtractor: mode=0 adds with carry in, mode=1 subtracts with
// borrow in; carry_borrow is the carry out or the borrow out respectively.
module adder_sub_32bit
  import addsub_arb_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  input  logic        mode,
  output logic [31:0] sum_diff,
  output logic        carry_borrow
);

  logic [32:0] add_r;
  logic [32:0] sub_r;

  // In 33-bit two's complement the top bit of a-b-c_in is set exactly when
  // the true result is negative, i.e. a < b + c_in.
  always_comb begin
    add_r = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
    sub_r = {1'b0, a} - {1'b0, b} - {32'b0, c_in};
    if (mode == MODE_SUB) begin
      sum_diff     = sub_r[31:0];
      carry_borrow = sub_r[32];
    end else begin
      sum_diff     = add_r[31:0];
      carry_borrow = add_r[32];
    end
  end

endmodule

// File: rtl/addsub_rr_arbiter_rr.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  winner_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Shares one adder_sub_32bit among NREQ requesters: round-robin grant into
// stage 1 (feeds the adder), result registered into stage 2 (drives rsp_*).
module addsub_rr_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  addsub_rr_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s1_valid_q;
  logic [IDW-1:0]  s1_id_q;
  s1_data_t        s1_q, s1_d;
  logic            s2_valid_q;
  logic [IDW-1:0]  s2_id_q;
  s2_data_t        s2_q, s2_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  winner;
  logic            adv1, adv2, accept;
  int              sel;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i    (bus.req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  adder_sub_32bit u_addsub (
    .a            (s1_q.a),
    .b            (s1_q.b),
    .c_in         (s1_q.cin),
    .mode         (s1_q.mode),
    .sum_diff     (s2_d.sum),
    .carry_borrow (s2_d.carry)
  );

  // Stage 1 can take a new operation whenever it is empty or moving on, so
  // requesters only see ready=0 when both stages are holding results.
  assign adv2   = ~s2_valid_q | bus.rsp_ready;
  assign adv1   = ~s1_valid_q | adv2;
  assign accept = adv1 & (|grant);

  assign bus.req_ready = adv1 ? grant : '0;

  always_comb begin
    sel       = int'(winner);
    s1_d.a    = bus.req_a[sel*DATA_W +: DATA_W];
    s1_d.b    = bus.req_b[sel*DATA_W +: DATA_W];
    s1_d.cin  = bus.req_cin[sel];
    s1_d.mode = bus.req_mode[sel];
    ptr_d     = ptr_q;
    if (accept) begin
      ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_id_q <= winner;
          s1_q    <= s1_d;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        s2_id_q    <= s1_id_q;
        s2_q       <= s2_d;
      end
    end
  end

  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_id    = s2_id_q;
  assign bus.rsp_sum   = s2_q.sum;
  assign bus.rsp_carry = s2_q.carry;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter with hand-computed expected results.
module tb_addsub_rr_arbiter;

  localparam int NREQ = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  addsub_rr_arbiter_if #(.NREQ(NREQ)) bus ();

  addsub_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic mode);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_cin[i]        = cin;
    bus.req_mode[i]       = mode;
    bus.req_valid[i]      = 1'b1;
  endtask

  task automatic drop_req(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic check_ready(input string tag, input logic [NREQ-1:0] exp);
    #1;
    check({tag, ".ready"}, 64'(bus.req_ready), 64'(exp));
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] id,
                           input logic [31:0] sum, input logic carry);
    check({tag, ".valid"}, 64'(bus.rsp_valid), 64'd1);
    check({tag, ".id"},    64'(bus.rsp_id),    64'(id));
    check({tag, ".sum"},   64'(bus.rsp_sum),   64'(sum));
    check({tag, ".carry"}, 64'(bus.rsp_carry), 64'(carry));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    check("rst.valid", 64'(bus.rsp_valid), 64'd0);
    check("rst.id",    64'(bus.rsp_id),    64'd0);
    check("rst.sum",   64'(bus.rsp_sum),   64'd0);
    check("rst.carry", 64'(bus.rsp_carry), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_mode  = '0;
    bus.rsp_ready = 1'b1;
    tick();
    pulse_reset();
    check_ready("idle", 4'b0000);

    // single add from requester 0
    set_req(0, 32'd5, 32'd7, 1'b0, 1'b0);
    check_ready("t1", 4'b0001);
    tick();
    drop_req(0);
    check_idle("t1.lat1");
    tick();
    check_rsp("t1", 0, 32'd12, 1'b0);
    tick();
    check_idle("t1.pulse");

    // subtract with borrow and add with carry out, requester 2
    set_req(2, 32'd3, 32'd5, 1'b0, 1'b1);
    check_ready("t2a", 4'b0100);
    tick();
    set_req(2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    check_ready("t2b", 4'b0100);
    tick();
    drop_req(2);
    check_rsp("t2a", 2, 32'hFFFF_FFFE, 1'b1);
    tick();
    check_rsp("t2b", 2, 32'h0, 1'b1);
    tick();
    check_idle("t2.end");

    // all four requesters continuously: a=100*(i+1), b=i+1 -> 101*(i+1)
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(100 * (i + 1)), 32'(i + 1), 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      check_ready($sformatf("t3.c%0d", c), 4'(1 << (c % 4)));
      tick();
      if (c >= 1) check_rsp($sformatf("t3.r%0d", c - 1), 32'((c - 1) % 4),
                            32'(101 * ((c - 1) % 4 + 1)), 1'b0);
    end
    bus.req_valid = '0;
    tick();
    check_rsp("t3.r5", 1, 32'd202, 1'b0);
    tick();
    check_idle("t3.end");

    // backpressure: requesters 1 and 3, consumer stalled
    pulse_reset();
    bus.rsp_ready = 1'b0;
    set_req(1, 32'd10, 32'd3, 1'b0, 1'b1);
    set_req(3, 32'd20, 32'd30, 1'b1, 1'b0);
    check_ready("t4.g1", 4'b0010);
    tick();
    drop_req(1);
    check_ready("t4.g3", 4'b1000);
    tick();
    drop_req(3);
    set_req(0, 32'd1, 32'd1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check_ready($sformatf("t4.stall%0d", c), 4'b0000);
      check_rsp($sformatf("t4.hold%0d", c), 1, 32'd7, 1'b0);
      tick();
    end
    check_rsp("t4.hold3", 1, 32'd7, 1'b0);
    bus.rsp_ready = 1'b1;
    check_ready("t4.resume", 4'b0001);
    tick();
    drop_req(0);
    check_rsp("t4.r3", 3, 32'd51, 1'b0);
    tick();
    check_rsp("t4.r0", 0, 32'd2, 1'b0);
    tick();
    check_idle("t4.end");

    // reset with both stages full; ptr is 1 here
    bus.rsp_ready = 1'b0;
    set_req(1, 32'd5, 32'd5, 1'b0, 1'b0);
    set_req(2, 32'd6, 32'd1, 1'b0, 1'b0);
    check_ready("t5.g1", 4'b0010);
    tick();
    drop_req(1);
    check_ready("t5.g2", 4'b0100);
    tick();
    drop_req(2);
    set_req(0, 32'd100, 32'd1, 1'b0, 1'b1);
    check_ready("t5.full", 4'b0000);
    check_rsp("t5.full", 1, 32'd10, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5.async.valid", 64'(bus.rsp_valid), 64'd0);
    check("t5.async.id",    64'(bus.rsp_id),    64'd0);
    check("t5.async.sum",   64'(bus.rsp_sum),   64'd0);
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(2, 32'd0, 32'd0, 1'b1, 1'b1);
    check_ready("t5.ptr0", 4'b0001);
    tick();
    drop_req(0);
    check_idle("t5.nostale");
    check_ready("t5.g2b", 4'b0100);
    tick();
    drop_req(2);
    check_rsp("t5.r0", 0, 32'd99, 1'b0);
    tick();
    check_rsp("t5.r2", 2, 32'hFFFF_FFFF, 1'b1);
    tick();
    check_idle("t5.end");

    // withdrawal: 3 drops out before its turn; ptr only moves on accepts
    pulse_reset();
    set_req(0, 32'd1, 32'd2, 1'b0, 1'b0);
    set_req(1, 32'd0, 32'd1, 1'b0, 1'b1);
    set_req(3, 32'd9, 32'd4, 1'b1, 1'b1);
    check_ready("t6.g0", 4'b0001);
    tick();
    drop_req(0);
    drop_req(3);
    check_ready("t6.g1", 4'b0010);
    tick();
    drop_req(1);
    check_ready("t6.none", 4'b0000);
    check_rsp("t6.r0", 0, 32'd3, 1'b0);
    tick();
    check_rsp("t6.r1", 1, 32'hFFFF_FFFF, 1'b1);
    set_req(0, 32'd1, 32'd2, 1'b0, 1'b0);
    set_req(1, 32'd0, 32'd1, 1'b0, 1'b1);
    set_req(3, 32'd9, 32'd4, 1'b1, 1'b1);
    check_ready("t6.g3", 4'b1000);
    tick();
    bus.req_valid = '0;
    check_idle("t6.gap");
    tick();
    check_rsp("t6.r3", 3, 32'd4, 1'b0);
    tick();
    check_idle("t6.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
